// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and width helpers for param_fifo
package fifo_pkg;

    typedef enum logic {
        REG_MODE  = 1'b0,
        FWFT_MODE = 1'b1
    } read_mode_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Occupancy spans 0..DEPTH, so it needs the same width as a wrapped pointer.
    function automatic int count_width(input int depth);
        return ptr_width(depth);
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// rtl/param_fifo_if.sv - producer/consumer handshake bundle for param_fifo
interface param_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    import fifo_pkg::*;

    localparam int CW = count_width(DEPTH);

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             full;
    logic             pop;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic             empty;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output push, push_data, pop, clr_err,
        input  full, pop_data, pop_valid, empty, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop, clr_err,
        output full, pop_data, pop_valid, empty, count,
               almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised synchronous FIFO with FWFT/registered read,
// occupancy, almost flags and sticky error flags
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 1,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic       clk,
    input  logic       rst,
    param_fifo_if.slave bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam read_mode_e MODE = (FWFT != 0) ? FWFT_MODE : REG_MODE;

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    occ;
    logic             empty_i, full_i;
    logic             push_ok, pop_ok;
    logic             overflow_q, underflow_q;
    logic [WIDTH-1:0] rdata;

    assign empty_i = (wr_ptr == rd_ptr);
    assign full_i  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign occ     = wr_ptr - rd_ptr;

    // Each side is judged against the pre-edge flags only, so a push and pop
    // at a boundary never let one another through.
    assign push_ok = bus.push & ~full_i;
    assign pop_ok  = bus.pop & ~empty_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.push && full_i)     overflow_q <= 1'b1;
            else if (bus.clr_err)       overflow_q <= 1'b0;
            if (bus.pop && empty_i)     underflow_q <= 1'b1;
            else if (bus.clr_err)       underflow_q <= 1'b0;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.push_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    generate
        if (MODE == FWFT_MODE) begin : g_fwft
            assign bus.pop_valid = ~empty_i;
            assign bus.pop_data  = rdata;
        end else begin : g_reg
            logic             pv_q;
            logic [WIDTH-1:0] pd_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv_q <= 1'b0;
                    pd_q <= '0;
                end else begin
                    pv_q <= pop_ok;
                    if (pop_ok) pd_q <= rdata;
                end
            end

            assign bus.pop_valid = pv_q;
            assign bus.pop_data  = pd_q;
        end
    endgenerate

    assign bus.empty        = empty_i;
    assign bus.full         = full_i;
    assign bus.count        = occ;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    // int compare keeps out-of-range thresholds (negative or > DEPTH) constant.
    assign bus.almost_full  = (int'(occ) >= AFULL_TH);
    assign bus.almost_empty = (int'(occ) <= AEMPTY_TH);

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - randomized scoreboard bench for param_fifo (FWFT and registered)
module tb_param_fifo;
    import fifo_pkg::*;

    localparam int W      = 8;
    localparam int D      = 16;
    localparam int AF0    = 14;
    localparam int AE0    = 2;
    localparam int AF1    = 20;
    localparam int AE1    = -1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         push = 1'b0;
    logic [W-1:0] push_data = '0;
    logic         pop = 1'b0;
    logic         clr_err = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    param_fifo_if #(.WIDTH(W), .DEPTH(D)) b0 ();
    param_fifo_if #(.WIDTH(W), .DEPTH(D)) b1 ();

    assign b0.push = push;  assign b0.push_data = push_data;
    assign b0.pop  = pop;   assign b0.clr_err   = clr_err;
    assign b1.push = push;  assign b1.push_data = push_data;
    assign b1.pop  = pop;   assign b1.clr_err   = clr_err;

    param_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(AF0), .AEMPTY_TH(AE0))
        u_fwft (.clk(clk), .rst(rst), .bus(b0.slave));
    param_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(AF1), .AEMPTY_TH(AE1))
        u_reg  (.clk(clk), .rst(rst), .bus(b1.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, words popped in registered
    // mode are queued in sb for the monitor to consume.
    logic [W-1:0] mdl[$];
    logic [W-1:0] sb[$];
    bit           m_ovf, m_udf, exp_pv;
    logic [W-1:0] last_reg = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl.delete();
            sb.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            exp_pv = 1'b0;
        end else begin
            bit pre_full, pre_empty;
            pre_full  = (mdl.size() == D);
            pre_empty = (mdl.size() == 0);
            exp_pv = 1'b0;
            if (pop && !pre_empty) begin
                sb.push_back(mdl.pop_front());
                exp_pv = 1'b1;
            end
            if (push && !pre_full) mdl.push_back(push_data);
            if (push && pre_full)  m_ovf = 1'b1;
            else if (clr_err)      m_ovf = 1'b0;
            if (pop && pre_empty)  m_udf = 1'b1;
            else if (clr_err)      m_udf = 1'b0;
        end
    end

    always @(negedge clk) begin
        int n;
        n = mdl.size();
        chk("count0",  32'(b0.count), 32'(n));
        chk("count1",  32'(b1.count), 32'(n));
        chk("empty0",  32'(b0.empty), 32'(n == 0));
        chk("full0",   32'(b0.full),  32'(n == D));
        chk("empty1",  32'(b1.empty), 32'(n == 0));
        chk("full1",   32'(b1.full),  32'(n == D));
        chk("afull0",  32'(b0.almost_full),  32'(n >= AF0));
        chk("aempty0", 32'(b0.almost_empty), 32'(n <= AE0));
        chk("afull1",  32'(b1.almost_full),  32'(n >= AF1));
        chk("aempty1", 32'(b1.almost_empty), 32'(n <= AE1));
        chk("ovf0",    32'(b0.overflow),  32'(m_ovf));
        chk("udf0",    32'(b0.underflow), 32'(m_udf));
        chk("ovf1",    32'(b1.overflow),  32'(m_ovf));
        chk("udf1",    32'(b1.underflow), 32'(m_udf));
        chk("pv_fwft", 32'(b0.pop_valid), 32'(n != 0));
        if (n != 0) chk("pd_fwft", 32'(b0.pop_data), 32'(mdl[0]));
        if (rst) last_reg = '0;
        chk("pv_reg", 32'(b1.pop_valid), 32'(exp_pv));
        if (b1.pop_valid) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'(1));
            if (sb.size() > 0) begin
                last_reg = sb.pop_front();
                chk("pd_reg", 32'(b1.pop_data), 32'(last_reg));
            end
        end else begin
            chk("pd_reg_hold", 32'(b1.pop_data), 32'(last_reg));
        end
    end

    task automatic step(input logic p, input logic [W-1:0] d, input logic po, input logic ce);
        push = p; push_data = d; pop = po; clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pd_reg", 32'(b1.pop_data), 32'(0));
        chk("rst_pv_reg", 32'(b1.pop_valid), 32'(0));
        rst = 1'b0;

        // basic FWFT ordering and registered read of the same words
        step(1, 8'hA1, 0, 0); step(1, 8'hB2, 0, 0); step(1, 8'hC3, 0, 0);
        chk("t1_count", 32'(b0.count), 32'(3));
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
        repeat (2) step(0, 8'h00, 0, 0);

        // fill to full, overflow drop, drain, then underflow
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        chk("t2_full", 32'(b0.full), 32'(1));
        step(1, 8'hFF, 0, 0);
        chk("t2_ovf", 32'(b0.overflow), 32'(1));
        for (int i = 0; i < 17; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // streaming with occupancy 5 across pointer wraps
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 40; i++) step(1, 8'(8'h80 + i), 1, 0);
        chk("t3_count", 32'(b0.count), 32'(5));
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);

        // push+pop at full and at empty
        for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0);
        step(1, 8'h55, 1, 0);
        chk("t4_count15", 32'(b0.count), 32'(15));
        for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h66, 1, 0);
        chk("t4_count1", 32'(b0.count), 32'(1));
        chk("t4_udf", 32'(b0.underflow), 32'(1));
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 1);

        // sticky set beats clr_err, then clr_err alone
        for (int i = 0; i < 16; i++) step(1, 8'(8'hC0 + i), 0, 0);
        step(1, 8'hEE, 0, 0);
        step(1, 8'hEF, 0, 1);
        chk("t6_ovf_stays", 32'(b0.overflow), 32'(1));
        step(0, 8'h00, 0, 1);
        chk("t6_ovf_clr", 32'(b0.overflow), 32'(0));
        for (int i = 0; i < 17; i++) step(0, 8'h00, 1, 0);

        // async reset mid-stream with count 7 and underflow set
        for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0, 0);
        push = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_count", 32'(b0.count), 32'(0));
        chk("t6_rst_empty", 32'(b0.empty), 32'(1));
        chk("t6_rst_udf",   32'(b0.underflow), 32'(0));
        chk("t6_rst_pv",    32'(b1.pop_valid), 32'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        step(1, 8'h99, 0, 0);
        chk("t6_after_rst", 32'(b0.count), 32'(1));
        step(0, 8'h00, 1, 0);

        // randomized traffic with drifting push/pop bias
        for (int blk = 0; blk < 8; blk++) begin
            int pp;
            pp = (blk % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 80; i++) begin
                step(logic'($urandom_range(0, 99) < pp), 8'($urandom),
                     logic'($urandom_range(0, 99) < (100 - pp)),
                     logic'($urandom_range(0, 19) == 0));
            end
        end
        for (int i = 0; i < 18; i++) step(0, 8'h00, 1, 0);
        repeat (2) step(0, 8'h00, 0, 0);
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
